ray_lane_scheduler: RTL and testbench
=====================================

# ray_lane_scheduler

Multi-lane successor to the single-lane ray tracing pipeline. It accepts ray directions from the ray generator and dispatches them round-robin to `NUM_LANES` parallel ray processor lanes. Lane results, which may complete out of order, are collected in a reorder buffer. The block emits an in-order pixel stream with frame/line markers to the external video sink. It sits between the ray generator and the video output, with the ray processor lanes hanging off its lane bus.

## Interface
- `NUM_LANES`, 4, number of processor lanes (1..8)
- `DIR_W`, 32, width of each ray direction component
- `DIM_W`, 13, image dimension width
- `ROB_DEPTH`, 8, reorder buffer slots; power of 2, ≥ `NUM_LANES`

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `image_width`, `image_height`  in  `DIM_W`  frame size; sampled at frame start
- `start_frame`  in  1  pulse; begins a frame; ignored unless IDLE
- `ray_valid`  in  1  generator has a ray
- `ray_ready`  out  1  block accepts a ray this cycle
- `ray_dir_x/y/z`  in  `DIR_W` each  ray direction
- `lane_start`  out  `NUM_LANES`  one-cycle start pulse per lane
- `lane_dir_x/y/z`  out  `NUM_LANES*DIR_W` each  per-lane registered direction
- `lane_done`  in  `NUM_LANES`  one-cycle completion pulse per lane
- `lane_rgb`  in  `NUM_LANES*24`  per-lane {r,g,b}; valid with `lane_done`
- `ready_external`  in  1  sink ready
- `valid_data_out`  out  1  pixel valid
- `r`, `g`, `b`  out  8 each  pixel colour
- `sof`  out  1  first pixel of frame
- `last_x`  out  1  last pixel of a line
- `frame_busy`  out  1  FSM not IDLE
- `frame_done`  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + `start_frame`: latch dimensions, compute `total = w*h` (2·`DIM_W` bits), clear counters, go to RUN.
  - If `total == 0`: go directly to IDLE with `frame_done` pulse, no pixels.
  - RUN: when `issued == total`, go to DRAIN.
  - DRAIN: when `retired == total`, pulse `frame_done` and go to IDLE.
- Dispatch conditions: `ray_ready = RUN && issued < total && any lane free && (issued - retired) < ROB_DEPTH`.
  - A lane is free when its `owned` bit is clear.
  - `owned` is set on dispatch and cleared on that lane's `lane_done`.
- Lane selection: round-robin. Search starts at the lane after the last granted one and takes the first free lane.
- On accept:
  - Register the direction into the chosen lane's `lane_dir`.
  - Pulse its `lane_start`.
  - Store `tag = issued mod ROB_DEPTH` in a per-lane tag register.
  - Increment `issued`.
- Completion: `lane_done[i]` with `owned[i]` writes `lane_rgb[i]` into ROB slot `tag[i]` and sets its valid bit.
  - Any number of lanes may complete in the same cycle; all writes are taken.
  - `lane_done` on a lane whose `owned` bit is clear is ignored.
- Output: when the head slot (`retired mod ROB_DEPTH`) is valid, present it on `r/g/b` with `valid_data_out`.
  - Transfer occurs when `valid_data_out && ready_external`. On transfer, clear the slot valid bit, increment `retired`, and advance x/y.
  - x wraps at `width-1`, incrementing y.
- Markers:
  - `sof = (x==0 && y==0)` while valid.
  - `last_x = (x == width-1)` while valid.
- Stall hold: while `valid_data_out && !ready_external`, `r/g/b/sof/last_x` are held stable.
- Slot reuse in the same cycle: completion write and head read of the same slot cannot collide, because the issue limit guarantees the slot is free.

## Timing
- Reset: all outputs 0, FSM IDLE, all counters, `owned`, and ROB valid bits cleared.
- Reset mid-frame discards all state. Lane completions arriving after reset are ignored because `owned` is clear.
- Dispatch latency: ray accepted at cycle N → `lane_start` high at N+1, with `lane_dir` valid at N+1.
- Completion latency: `lane_done` at cycle M → earliest `valid_data_out` at M+1, since the ROB is registered.
- Throughput: up to one ray accepted and one pixel emitted per cycle.
- `ray_ready` is combinational from registered state only; it has no path from `ray_valid`.
- `frame_done` asserts the cycle after the final pixel transfer.

## Test plan
- Reset check: assert `reset_n` low, then release → all outputs 0, `ray_ready` 0, `frame_busy` 0.
- 4x2 frame, 4 lanes, fixed lane latency 5, sink always ready → 8 pixels in order.
  - `sof` on pixel 0; `last_x` on pixels 3 and 7.
  - `frame_done` pulses once, then `frame_busy` is 0.
- Out-of-order completion: lane latencies 9, 3, 6, 1; lane rgb = tag-coded (`0x0000kk`) → output colours `0x000000`, `0x000001`, … in issue order.
- Backpressure: hold `ready_external` low for 20 cycles on an 8x1 frame, `ROB_DEPTH=8`.
  - `ray_ready` drops after 8 issues.
  - Outputs stay stable while stalled.
  - All 8 pixels delivered after release, with none lost or duplicated.
- Zero-size frame: `width=0`, `start_frame` → `frame_done` next cycle, no `valid_data_out`, no `lane_start`.
- Mid-frame reset: reset after 3 pixels of a 4x4 frame, with a stale `lane_done` pulse issued after reset.
  - Stale pulse is ignored.
  - A new 2x2 frame completes correctly with `sof` on its first pixel.

Source files
------------

// File: rtl/ray_lane_scheduler_if.sv
// ray_lane_scheduler_if: ray input stream, per-lane processor bus and pixel output stream
// Ports: ray_valid/ray_ready/ray_dir_*; lane_start/lane_dir_*/lane_done/lane_rgb; ready_external/valid_data_out/r/g/b/sof/last_x
interface ray_lane_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int DIR_W = 32
);
  logic ray_valid, ray_ready;
  logic [DIR_W-1:0] ray_dir_x, ray_dir_y, ray_dir_z;
  logic [NUM_LANES-1:0] lane_start, lane_done;
  logic [NUM_LANES*DIR_W-1:0] lane_dir_x, lane_dir_y, lane_dir_z;
  logic [NUM_LANES*24-1:0] lane_rgb;
  logic ready_external, valid_data_out, sof, last_x;
  logic [7:0] r, g, b;
  modport slave (
    input ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, lane_done, lane_rgb, ready_external,
    output ray_ready, lane_start, lane_dir_x, lane_dir_y, lane_dir_z, valid_data_out, r, g, b, sof, last_x
  );
  modport master (
    output ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, lane_done, lane_rgb, ready_external,
    input ray_ready, lane_start, lane_dir_x, lane_dir_y, lane_dir_z, valid_data_out, r, g, b, sof, last_x
  );
endinterface

// File: rtl/ray_lane_scheduler.sv
// ray_lane_scheduler: round-robin ray dispatch to NUM_LANES lanes with reorder buffer and in-order pixel output
// Ports: clk, reset_n (async low), image_width/height, start_frame, frame_busy, frame_done, bus (ray/lane/pixel streams)
module ray_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int DIR_W = 32,
  parameter int DIM_W = 13,
  parameter int ROB_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [DIM_W-1:0] image_width,
  input  logic [DIM_W-1:0] image_height,
  input  logic start_frame,
  output logic frame_busy,
  output logic frame_done,
  ray_lane_scheduler_if.slave bus
);
  localparam int CW = 2*DIM_W;
  localparam int TW = $clog2(ROB_DEPTH);
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int VW = NUM_LANES*DIR_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] total_q, total_d, issued_q, issued_d, retired_q, retired_d, start_total;
  logic [NUM_LANES-1:0] owned_q, owned_d, start_q, start_d;
  logic [TW-1:0] tag_q [NUM_LANES];
  logic [TW-1:0] tag_d [NUM_LANES];
  logic [LW-1:0] ptr_q, ptr_d, pick;
  logic [VW-1:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [23:0] rob_q [ROB_DEPTH];
  logic [23:0] rob_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rv_q, rv_d;
  logic done_q, done_d, any_free, accept, xfer;
  logic [TW-1:0] head;
  assign start_total = CW'(image_width) * CW'(image_height);
  assign head = retired_q[TW-1:0];
  assign bus.ray_ready = state_q == RUN && issued_q < total_q && any_free && (issued_q - retired_q) < CW'(ROB_DEPTH);
  assign accept = bus.ray_ready && bus.ray_valid;
  assign bus.valid_data_out = rv_q[head];
  assign {bus.r, bus.g, bus.b} = rob_q[head];
  assign bus.sof = bus.valid_data_out && x_q == '0 && y_q == '0;
  assign bus.last_x = bus.valid_data_out && x_q == w_q - DIM_W'(1);
  assign xfer = bus.valid_data_out && bus.ready_external;
  assign bus.lane_start = start_q;
  assign bus.lane_dir_x = dx_q;
  assign bus.lane_dir_y = dy_q;
  assign bus.lane_dir_z = dz_q;
  assign frame_busy = state_q != IDLE;
  assign frame_done = done_q;
  // Walk downward so the last hit is the nearest free lane after the previous grant.
  always_comb begin
    any_free = 1'b0;
    pick = '0;
    for (int i = NUM_LANES; i >= 1; i--)
      if (!owned_q[LW'((int'(ptr_q) + i) % NUM_LANES)]) begin
        any_free = 1'b1;
        pick = LW'((int'(ptr_q) + i) % NUM_LANES);
      end
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    x_d = x_q;
    y_d = y_q;
    total_d = total_q;
    issued_d = issued_q;
    retired_d = retired_q;
    owned_d = owned_q;
    start_d = '0;
    tag_d = tag_q;
    ptr_d = accept ? pick : ptr_q;
    dx_d = dx_q;
    dy_d = dy_q;
    dz_d = dz_q;
    rob_d = rob_q;
    rv_d = rv_q;
    done_d = 1'b0;
    if (state_q == IDLE && start_frame) begin
      w_d = image_width;
      total_d = start_total;
      issued_d = '0;
      retired_d = '0;
      x_d = '0;
      y_d = '0;
      done_d = start_total == '0;
      state_d = start_total == '0 ? IDLE : RUN;
    end
    if (accept) begin
      start_d[pick] = 1'b1;
      owned_d[pick] = 1'b1;
      tag_d[pick] = issued_q[TW-1:0];
      issued_d = issued_q + CW'(1);
      dx_d[int'(pick)*DIR_W +: DIR_W] = bus.ray_dir_x;
      dy_d[int'(pick)*DIR_W +: DIR_W] = bus.ray_dir_y;
      dz_d[int'(pick)*DIR_W +: DIR_W] = bus.ray_dir_z;
    end
    // The issue window keeps a lane's tag slot disjoint from the head being read.
    for (int i = 0; i < NUM_LANES; i++)
      if (bus.lane_done[i] && owned_q[i]) begin
        owned_d[i] = 1'b0;
        rob_d[tag_q[i]] = bus.lane_rgb[i*24 +: 24];
        rv_d[tag_q[i]] = 1'b1;
      end
    if (xfer) begin
      rv_d[head] = 1'b0;
      retired_d = retired_q + CW'(1);
      x_d = x_q == w_q - DIM_W'(1) ? '0 : x_q + DIM_W'(1);
      y_d = x_q == w_q - DIM_W'(1) ? y_q + DIM_W'(1) : y_q;
    end
    // Finishing on the final transfer makes frame_done land the cycle after it.
    if (state_q != IDLE && xfer && retired_q + CW'(1) == total_q) begin
      state_d = IDLE;
      done_d = 1'b1;
    end else if (state_q == RUN && issued_q == total_q) state_d = DRAIN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      w_q <= '0;
      x_q <= '0;
      y_q <= '0;
      total_q <= '0;
      issued_q <= '0;
      retired_q <= '0;
      owned_q <= '0;
      start_q <= '0;
      ptr_q <= LW'(NUM_LANES - 1);
      dx_q <= '0;
      dy_q <= '0;
      dz_q <= '0;
      rv_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) tag_q[i] <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      x_q <= x_d;
      y_q <= y_d;
      total_q <= total_d;
      issued_q <= issued_d;
      retired_q <= retired_d;
      owned_q <= owned_d;
      start_q <= start_d;
      ptr_q <= ptr_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      dz_q <= dz_d;
      rv_q <= rv_d;
      done_q <= done_d;
      tag_q <= tag_d;
      rob_q <= rob_d;
    end
endmodule

// File: tb/tb_ray_lane_scheduler.sv
// tb_ray_lane_scheduler: lane models plus in-order pixel scoreboard for ray_lane_scheduler
module tb_ray_lane_scheduler;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int MW = 13;
  typedef struct {
    int w;
    int h;
    int l0;
    int l1;
    int l2;
    int l3;
    bit rnd;
    int exp_pix;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_frame = 1'b0;
  logic [MW-1:0] image_width = '0;
  logic [MW-1:0] image_height = '0;
  logic frame_busy, frame_done;
  ray_lane_scheduler_if #(.NUM_LANES(NL), .DIR_W(DW)) bus();
  ray_lane_scheduler #(.NUM_LANES(NL), .DIR_W(DW), .DIM_W(MW), .ROB_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .image_width(image_width), .image_height(image_height),
    .start_frame(start_frame), .frame_busy(frame_busy), .frame_done(frame_done), .bus(bus)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [25:0] sb[$];
  int cnt[NL], lat[NL];
  logic [23:0] lrgb[NL];
  bit stale_req = 0, gen_on = 0, sink_mode = 0, sink_val = 1;
  int gen_k = 0, gen_n = 0, cur_w = 1, pix_cnt = 0, start_cnt = 0, done_cnt = 0;
  vec_t tbl[6];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [23:0] exp_rgb(input int k);
    logic [31:0] kk, yy, zz;
    kk = k;
    yy = k*7 + 1;
    zz = ~kk;
    return {yy[7:0], zz[7:0], kk[7:0]};
  endfunction
  task automatic tick();
    logic [NL-1:0] dv;
    logic [NL*24-1:0] rv;
    @(negedge clk);
    if (reset_n) begin
      if (bus.ray_valid && bus.ray_ready) begin
        sb.push_back({exp_rgb(gen_k), gen_k == 0, (gen_k % cur_w) == cur_w - 1});
        gen_k++;
      end
      if (bus.valid_data_out && bus.ready_external) begin
        pix_cnt++;
        if (sb.size() == 0) check("pixel_extra", 1, 0);
        else check("pixel", {bus.r, bus.g, bus.b, bus.sof, bus.last_x}, sb.pop_front());
      end
      done_cnt += int'(frame_done);
      start_cnt += $countones(bus.lane_start);
    end
    dv = '0;
    rv = '0;
    for (int i = 0; i < NL; i++)
      if (bus.lane_start[i]) begin
        cnt[i] = lat[i];
        lrgb[i] = {bus.lane_dir_y[i*DW +: 8], bus.lane_dir_z[i*DW +: 8], bus.lane_dir_x[i*DW +: 8]};
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          dv[i] = 1'b1;
          rv[i*24 +: 24] = lrgb[i];
        end
      end
    if (stale_req) begin
      dv = '1;
      rv = '1;
      stale_req = 0;
    end
    bus.lane_done = dv;
    bus.lane_rgb = rv;
    @(posedge clk);
    #1;
    bus.ray_valid = gen_on && gen_k < gen_n;
    bus.ray_dir_x = 32'(gen_k);
    bus.ray_dir_y = 32'(gen_k*7 + 1);
    bus.ray_dir_z = ~32'(gen_k);
    bus.ready_external = sink_mode ? ($urandom_range(0, 3) != 0) : sink_val;
  endtask
  task automatic begin_frame(input int w, input int h, input int l0, input int l1, input int l2, input int l3, input bit rnd);
    lat = '{l0, l1, l2, l3};
    sink_mode = rnd;
    cur_w = w > 0 ? w : 1;
    gen_k = 0;
    gen_n = w*h;
    gen_on = 1;
    pix_cnt = 0;
    start_cnt = 0;
    done_cnt = 0;
    image_width = MW'(w);
    image_height = MW'(h);
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask
  task automatic finish_frame(input string nm, input int exp_pix);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    check({nm, "_done_once"}, done_cnt, 1);
    check({nm, "_pixels"}, pix_cnt, exp_pix);
    check({nm, "_starts"}, start_cnt, exp_pix);
    check({nm, "_busy_after"}, frame_busy, 0);
    check({nm, "_sb_empty"}, sb.size(), 0);
    gen_on = 0;
    sink_mode = 0;
    sink_val = 1;
  endtask
  initial begin
    logic [25:0] snap;
    bit have;
    int bad, cyc;
    tbl[0] = '{4, 2, 5, 5, 5, 5, 0, 8};
    tbl[1] = '{4, 2, 9, 3, 6, 1, 0, 8};
    tbl[2] = '{3, 3, 2, 7, 1, 4, 1, 9};
    tbl[3] = '{5, 1, 1, 1, 1, 1, 0, 5};
    tbl[4] = '{1, 4, 3, 8, 2, 6, 1, 4};
    tbl[5] = '{2, 10, 1, 2, 3, 4, 1, 20};
    for (int i = 0; i < NL; i++) cnt[i] = 0;
    bus.ray_valid = 0;
    bus.ray_dir_x = '0;
    bus.ray_dir_y = '0;
    bus.ray_dir_z = '0;
    bus.lane_done = '0;
    bus.lane_rgb = '0;
    bus.ready_external = 1;
    repeat (2) tick();
    check("rst_busy_in_reset", frame_busy, 0);
    check("rst_ready_in_reset", bus.ray_ready, 0);
    reset_n = 1;
    tick();
    check("rst_ready", bus.ray_ready, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_valid", bus.valid_data_out, 0);
    check("rst_pixel", {bus.r, bus.g, bus.b, bus.sof, bus.last_x}, 0);
    check("rst_lane", {bus.lane_start, bus.lane_dir_x, bus.lane_dir_y, bus.lane_dir_z}, 0);
    check("rst_done", frame_done, 0);
    for (int i = 0; i < 6; i++) begin
      begin_frame(tbl[i].w, tbl[i].h, tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3, tbl[i].rnd);
      check($sformatf("v%0d_busy", i), frame_busy, 1);
      finish_frame($sformatf("v%0d", i), tbl[i].exp_pix);
    end
    sink_val = 0;
    begin_frame(12, 1, 1, 2, 3, 4, 0);
    have = 0;
    bad = 0;
    snap = '0;
    repeat (20) begin
      tick();
      if (bus.valid_data_out) begin
        if (!have) snap = {bus.r, bus.g, bus.b, bus.sof, bus.last_x};
        else if ({bus.r, bus.g, bus.b, bus.sof, bus.last_x} != snap) bad++;
        have = 1;
      end
    end
    check("bp_rob_limit_starts", start_cnt, 8);
    check("bp_ready_low", bus.ray_ready, 0);
    check("bp_valid_held", bus.valid_data_out, 1);
    check("bp_stable", bad, 0);
    check("bp_head_pixel", snap, sb[0]);
    sink_val = 1;
    finish_frame("bp", 12);
    begin_frame(0, 5, 1, 1, 1, 1, 0);
    check("zero_done_next", frame_done, 1);
    check("zero_busy", frame_busy, 0);
    repeat (4) tick();
    check("zero_done_drop", frame_done, 0);
    check("zero_no_start", start_cnt, 0);
    check("zero_no_pixel", pix_cnt, 0);
    gen_on = 0;
    begin_frame(4, 4, 2, 3, 4, 5, 0);
    cyc = 0;
    while (pix_cnt < 3 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("mr_three_pixels", pix_cnt, 3);
    reset_n = 0;
    gen_on = 0;
    sb.delete();
    repeat (2) tick();
    reset_n = 1;
    tick();
    check("mr_busy", frame_busy, 0);
    check("mr_ready", bus.ray_ready, 0);
    check("mr_valid", bus.valid_data_out, 0);
    stale_req = 1;
    repeat (12) tick();
    check("mr_stale_ignored", bus.valid_data_out, 0);
    check("mr_still_idle", frame_busy, 0);
    begin_frame(2, 2, 3, 1, 2, 4, 0);
    finish_frame("mr_2x2", 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
